// File: rtl/jtpopeye_dwnld_ctrl_if.sv
// Bus bundle for jtpopeye_dwnld_ctrl: host ioctl byte stream, SDRAM write
// request channel and PROM write port. The slave modport is the sequencer's
// view; the master modport is the host/memory side.
interface jtpopeye_dwnld_ctrl_if;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic        sdram_req;
    logic        sdram_ack;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_data;
    logic [1:0]  sdram_mask;
    logic [9:0]  prom_addr;
    logic [7:0]  prom_data;
    logic [5:0]  prom_we;

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        output ioctl_wait, sdram_req, sdram_addr, sdram_data, sdram_mask,
               prom_addr, prom_data, prom_we
    );

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        input  ioctl_wait, sdram_req, sdram_addr, sdram_data, sdram_mask,
               prom_addr, prom_data, prom_we
    );
endinterface

// File: rtl/jtpopeye_dwnld_ctrl.sv
// Download sequencer: routes host ioctl bytes either into a small FIFO that
// feeds the SDRAM controller (req/ack) or to six on-chip PROM write strobes,
// throttles the host when the FIFO is full, and holds the game in reset until
// all writes have retired plus a guard interval.
// Optional build macro JTPOPEYE_DWNLD_CHK_EN adds a 16-bit byte checksum output.
module jtpopeye_dwnld_ctrl #(
    parameter int PROM_START = 65536,
    parameter int FIFO_AW    = 2,
    parameter int RST_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtpopeye_dwnld_ctrl_if.slave  bus,
    output logic                  ovf,
    output logic                  dwnld_busy,
    output logic                  game_rst_n
`ifdef JTPOPEYE_DWNLD_CHK_EN
    ,
    output logic [15:0]           chk
`endif
);

    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam int                HW        = $clog2(RST_HOLD + 1);
    localparam logic [21:0]       PROM_BASE = 22'(PROM_START);
    localparam logic [21:0]       PROM_SPAN = 22'd6144;
    localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [HW-1:0]     HOLD_INIT = HW'(RST_HOLD);

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    typedef struct packed {
        logic [20:0] waddr;
        logic [7:0]  data;
        logic        a0;
    } fifo_entry_t;

    fifo_entry_t          fifo_mem_q [DEPTH];
    fifo_entry_t          fifo_mem_d [DEPTH];
    fifo_entry_t          head;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;

    state_t               state_q, state_d;
    logic                 sdram_req_q, sdram_req_d;
    logic [21:0]          sdram_addr_q, sdram_addr_d;
    logic [15:0]          sdram_data_q, sdram_data_d;
    logic [1:0]           sdram_mask_q, sdram_mask_d;

    logic [9:0]           prom_addr_q, prom_addr_d;
    logic [7:0]           prom_data_q, prom_data_d;
    logic [5:0]           prom_we_q, prom_we_d;

    logic                 busy_q, busy_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 game_rst_n_q, game_rst_n_d;

    logic [21:0]          prom_off;
    logic                 below_prom;
    logic                 sdram_wr;
    logic                 prom_hit;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;

    assign below_prom = bus.ioctl_addr < PROM_BASE;
    assign prom_off   = bus.ioctl_addr - PROM_BASE;
    assign sdram_wr   = bus.ioctl_wr && below_prom;
    assign prom_hit   = bus.ioctl_wr && !below_prom && (prom_off < PROM_SPAN);
    assign fifo_full  = (count_q == FULL_CNT);
    assign push       = sdram_wr && !fifo_full;
    assign pop        = (state_q == ST_REQ) && bus.sdram_ack;
    assign head       = fifo_mem_q[rd_ptr_q];

    // FIFO bookkeeping: a full FIFO rejects the byte even if a pop happens in the same cycle
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{waddr: bus.ioctl_addr[21:1],
                                     data:  bus.ioctl_data,
                                     a0:    bus.ioctl_addr[0]};
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (sdram_wr && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: load the head into the request fields, then hold them until acked
    always_comb begin
        state_d      = state_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        sdram_data_d = sdram_data_q;
        sdram_mask_d = sdram_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    sdram_addr_d = {1'b0, head.waddr};
                    sdram_data_d = {head.data, head.data};
                    sdram_mask_d = {head.a0, ~head.a0};
                    sdram_req_d  = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    sdram_req_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                sdram_req_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // PROM path: one-cycle one-hot strobe selected by the 1 KiB bank of the offset
    always_comb begin
        prom_addr_d = prom_addr_q;
        prom_data_d = prom_data_q;
        prom_we_d   = 6'b000000;
        if (prom_hit) begin
            prom_addr_d = prom_off[9:0];
            prom_data_d = bus.ioctl_data;
            prom_we_d   = 6'b000001 << prom_off[12:10];
        end
    end

    // Busy tracking and game reset guard counter
    always_comb begin
        busy_d       = bus.downloading || (count_q != '0) || sdram_req_q;
        hold_d       = hold_q;
        game_rst_n_d = 1'b0;
        if (busy_q) begin
            hold_d = HOLD_INIT;
        end else begin
            if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end
            game_rst_n_d = (hold_q <= HW'(1));
        end
    end

    // State registers for the whole block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_q   <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            sdram_data_q <= '0;
            sdram_mask_q <= '0;
            prom_addr_q  <= '0;
            prom_data_q  <= '0;
            prom_we_q    <= '0;
            busy_q       <= 1'b0;
            hold_q       <= HOLD_INIT;
            game_rst_n_q <= 1'b0;
        end else begin
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_data_q <= sdram_data_d;
            sdram_mask_q <= sdram_mask_d;
            prom_addr_q  <= prom_addr_d;
            prom_data_q  <= prom_data_d;
            prom_we_q    <= prom_we_d;
            busy_q       <= busy_d;
            hold_q       <= hold_d;
            game_rst_n_q <= game_rst_n_d;
        end
    end

    assign bus.ioctl_wait = fifo_full;
    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.sdram_data = sdram_data_q;
    assign bus.sdram_mask = sdram_mask_q;
    assign bus.prom_addr  = prom_addr_q;
    assign bus.prom_data  = prom_data_q;
    assign bus.prom_we    = prom_we_q;
    assign ovf            = ovf_q;
    assign dwnld_busy     = busy_q;
    assign game_rst_n     = game_rst_n_q;

`ifdef JTPOPEYE_DWNLD_CHK_EN
    logic [15:0] chk_q, chk_d;
    logic        dl_q;
    logic        accept;

    assign accept = push || prom_hit;

    // Checksum of accepted bytes, restarted when a new download window opens
    always_comb begin
        chk_d = (bus.downloading && !dl_q) ? 16'h0000 : chk_q;
        if (accept) begin
            chk_d = chk_d + {8'h00, bus.ioctl_data};
        end
    end

    // Checksum and download-edge registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
            dl_q  <= 1'b0;
        end else begin
            chk_q <= chk_d;
            dl_q  <= bus.downloading;
        end
    end

    assign chk = chk_q;
`endif

endmodule

// File: tb/tb_jtpopeye_dwnld_ctrl.sv
// Self-checking bench for jtpopeye_dwnld_ctrl: table-driven single-byte
// vectors for both paths, then hand-written backpressure, reset-release,
// async-reset and (optionally) checksum sequences.
module tb_jtpopeye_dwnld_ctrl;

    localparam int RST_HOLD = 16;

    logic clk;
    logic rst_n;
    logic ovf;
    logic dwnld_busy;
    logic game_rst_n;
`ifdef JTPOPEYE_DWNLD_CHK_EN
    logic [15:0] chk;
`endif

    int errors = 0;
    int checks = 0;

    jtpopeye_dwnld_ctrl_if bus ();

    jtpopeye_dwnld_ctrl #(
        .PROM_START (65536),
        .FIFO_AW    (2),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ovf        (ovf),
        .dwnld_busy (dwnld_busy),
        .game_rst_n (game_rst_n)
`ifdef JTPOPEYE_DWNLD_CHK_EN
        ,
        .chk        (chk)
`endif
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic        exp_req;
        logic [21:0] exp_saddr;
        logic [15:0] exp_sdata;
        logic [1:0]  exp_mask;
        logic [5:0]  exp_we;
        logic [9:0]  exp_paddr;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    logic [21:0] bp_addr  [5];
    logic [7:0]  bp_data  [5];
    logic [21:0] bp_saddr [4];
    logic [15:0] bp_sdata [4];
    logic [1:0]  bp_mask  [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [21:0] addr, input logic [7:0] data);
        bus.ioctl_wr   = wr;
        bus.ioctl_addr = addr;
        bus.ioctl_data = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReq(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.sdram_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({name, " req seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic serviceReq(input string name);
        waitReq(name);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
    endtask

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;

        vecs[0] = '{22'h000101, 8'hA5, 1'b1, 22'h000080, 16'hA5A5, 2'b10, 6'b000000, 10'h000};
        vecs[1] = '{22'h000000, 8'h5A, 1'b1, 22'h000000, 16'h5A5A, 2'b01, 6'b000000, 10'h000};
        vecs[2] = '{22'h00FFFF, 8'h12, 1'b1, 22'h007FFF, 16'h1212, 2'b10, 6'b000000, 10'h000};
        vecs[3] = '{22'h010C07, 8'h3C, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b001000, 10'h007};
        vecs[4] = '{22'h010000, 8'h11, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b000001, 10'h000};
        vecs[5] = '{22'h0117FF, 8'h77, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b100000, 10'h3FF};
        vecs[6] = '{22'h010400, 8'h01, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b000010, 10'h000};
        vecs[7] = '{22'h011800, 8'h99, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b000000, 10'h000};
        vecs[8] = '{22'h3FFFFF, 8'h42, 1'b0, 22'h000000, 16'h0000, 2'b00, 6'b000000, 10'h000};

        bp_addr  = '{22'h000010, 22'h000013, 22'h000014, 22'h000017, 22'h000018};
        bp_data  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        bp_saddr = '{22'h000008, 22'h000009, 22'h00000A, 22'h00000B};
        bp_sdata = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        bp_mask  = '{2'b01, 2'b10, 2'b01, 2'b10};

        // ---------------- reset state ----------------
        rst_n           = 1'b0;
        bus.downloading = 1'b1;
        bus.sdram_ack   = 1'b0;
        applyStimulus(1'b0, 22'h0, 8'h0);
        tick();
        tick();
        checkOutput("rst sdram_req",  {31'd0, bus.sdram_req}, 32'd0);
        checkOutput("rst sdram_addr", {10'd0, bus.sdram_addr}, 32'd0);
        checkOutput("rst sdram_data", {16'd0, bus.sdram_data}, 32'd0);
        checkOutput("rst sdram_mask", {30'd0, bus.sdram_mask}, 32'd0);
        checkOutput("rst prom_we",    {26'd0, bus.prom_we}, 32'd0);
        checkOutput("rst prom_addr",  {22'd0, bus.prom_addr}, 32'd0);
        checkOutput("rst prom_data",  {24'd0, bus.prom_data}, 32'd0);
        checkOutput("rst ovf",        {31'd0, ovf}, 32'd0);
        checkOutput("rst ioctl_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        checkOutput("rst game_rst_n", {31'd0, game_rst_n}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("busy after release", {31'd0, dwnld_busy}, 32'd1);

        // ---------------- table-driven single bytes ----------------
        $display("[TB] single-byte vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, vecs[i].addr, vecs[i].data);
            tick();
            applyStimulus(1'b0, 22'h0, 8'h0);
            checkOutput($sformatf("vec%0d prom_we", i), {26'd0, bus.prom_we}, {26'd0, vecs[i].exp_we});
            if (vecs[i].exp_we != 6'b0) begin
                checkOutput($sformatf("vec%0d prom_addr", i), {22'd0, bus.prom_addr}, {22'd0, vecs[i].exp_paddr});
                checkOutput($sformatf("vec%0d prom_data", i), {24'd0, bus.prom_data}, {24'd0, vecs[i].data});
            end
            tick();
            checkOutput($sformatf("vec%0d prom_we one-shot", i), {26'd0, bus.prom_we}, 32'd0);
            checkOutput($sformatf("vec%0d sdram_req", i), {31'd0, bus.sdram_req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                checkOutput($sformatf("vec%0d sdram_addr", i), {10'd0, bus.sdram_addr}, {10'd0, vecs[i].exp_saddr});
                checkOutput($sformatf("vec%0d sdram_data", i), {16'd0, bus.sdram_data}, {16'd0, vecs[i].exp_sdata});
                checkOutput($sformatf("vec%0d sdram_mask", i), {30'd0, bus.sdram_mask}, {30'd0, vecs[i].exp_mask});
                bus.sdram_ack = 1'b1;
                tick();
                bus.sdram_ack = 1'b0;
                checkOutput($sformatf("vec%0d req cleared", i), {31'd0, bus.sdram_req}, 32'd0);
            end
            tick();
            checkOutput($sformatf("vec%0d fifo drained", i), {31'd0, bus.sdram_req}, 32'd0);
            checkOutput($sformatf("vec%0d ioctl_wait", i), {31'd0, bus.ioctl_wait}, 32'd0);
            checkOutput($sformatf("vec%0d ovf", i), {31'd0, ovf}, 32'd0);
        end

        // ---------------- backpressure ----------------
        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, bp_addr[i], bp_data[i]);
            tick();
            checkOutput($sformatf("bp%0d ioctl_wait", i), {31'd0, bus.ioctl_wait}, (i >= 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("bp%0d ovf", i), {31'd0, ovf}, (i == 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 22'h0, 8'h0);
        for (int k = 0; k < 4; k++) begin
            waitReq($sformatf("bp drain%0d", k));
            checkOutput($sformatf("bp drain%0d addr", k), {10'd0, bus.sdram_addr}, {10'd0, bp_saddr[k]});
            checkOutput($sformatf("bp drain%0d data", k), {16'd0, bus.sdram_data}, {16'd0, bp_sdata[k]});
            checkOutput($sformatf("bp drain%0d mask", k), {30'd0, bus.sdram_mask}, {30'd0, bp_mask[k]});
            bus.sdram_ack = 1'b1;
            tick();
            bus.sdram_ack = 1'b0;
            checkOutput($sformatf("bp drain%0d wait", k), {31'd0, bus.ioctl_wait}, 32'd0);
        end
        cyc = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.sdram_req === 1'b1) cyc++;
        end
        checkOutput("bp no 5th request", cyc, 32'd0);
        checkOutput("bp ovf sticky", {31'd0, ovf}, 32'd1);

        // ---------------- reset release guard ----------------
        $display("[TB] reset release");
        applyStimulus(1'b1, 22'h000030, 8'h21);
        tick();
        applyStimulus(1'b1, 22'h000031, 8'h22);
        bus.downloading = 1'b0;
        tick();
        applyStimulus(1'b0, 22'h0, 8'h0);
        for (int k = 0; k < 2; k++) begin
            waitReq($sformatf("rr req%0d", k));
            for (int d = 0; d < 3; d++) begin
                tick();
                checkOutput($sformatf("rr req%0d held", k), {31'd0, bus.sdram_req}, 32'd1);
                checkOutput($sformatf("rr req%0d addr stable", k), {10'd0, bus.sdram_addr}, 32'h18);
                checkOutput($sformatf("rr game held%0d", k), {31'd0, game_rst_n}, 32'd0);
            end
            checkOutput($sformatf("rr req%0d mask", k), {30'd0, bus.sdram_mask}, (k == 0) ? 32'd1 : 32'd2);
            bus.sdram_ack = 1'b1;
            tick();
            bus.sdram_ack = 1'b0;
        end
        for (int n = 0; n < 10 && dwnld_busy === 1'b1; n++) tick();
        checkOutput("rr busy fell", {31'd0, dwnld_busy}, 32'd0);
        checkOutput("rr game low at busy fall", {31'd0, game_rst_n}, 32'd0);
        cyc = 0;
        for (int c = 1; c <= RST_HOLD + 5; c++) begin
            tick();
            if (game_rst_n === 1'b1) begin
                cyc = c;
                break;
            end
        end
        checkOutput("rr game_rst_n delay", cyc, RST_HOLD);
        bus.downloading = 1'b1;
        tick();
        checkOutput("rr busy rises", {31'd0, dwnld_busy}, 32'd1);
        checkOutput("rr game still high", {31'd0, game_rst_n}, 32'd1);
        tick();
        checkOutput("rr game drops", {31'd0, game_rst_n}, 32'd0);

        // ---------------- async reset mid-request ----------------
        $display("[TB] async reset mid-request");
        applyStimulus(1'b1, 22'h000040, 8'h66);
        tick();
        applyStimulus(1'b1, 22'h000042, 8'h67);
        tick();
        applyStimulus(1'b0, 22'h0, 8'h0);
        checkOutput("ar req before reset", {31'd0, bus.sdram_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar req dropped", {31'd0, bus.sdram_req}, 32'd0);
        checkOutput("ar ovf cleared", {31'd0, ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (bus.sdram_req === 1'b1) cyc++;
        end
        checkOutput("ar fifo empty", cyc, 32'd0);
        checkOutput("ar game_rst_n", {31'd0, game_rst_n}, 32'd0);

`ifdef JTPOPEYE_DWNLD_CHK_EN
        // ---------------- checksum ----------------
        $display("[TB] checksum");
        bus.downloading = 1'b0;
        tick();
        bus.downloading = 1'b1;
        tick();
        applyStimulus(1'b1, 22'h000050, 8'hFF);
        tick();
        applyStimulus(1'b0, 22'h0, 8'h0);
        serviceReq("chk byte0");
        applyStimulus(1'b1, 22'h010001, 8'h02);
        tick();
        applyStimulus(1'b1, 22'h011800, 8'h80);
        tick();
        applyStimulus(1'b1, 22'h000051, 8'h10);
        tick();
        applyStimulus(1'b0, 22'h0, 8'h0);
        serviceReq("chk byte2");
        bus.downloading = 1'b0;
        tick();
        for (int n = 0; n < 10 && dwnld_busy === 1'b1; n++) tick();
        checkOutput("chk busy fell", {31'd0, dwnld_busy}, 32'd0);
        checkOutput("chk sum", {16'd0, chk}, 32'h0111);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtpopeye_dwnld_ctrl.md
Name: jtpopeye_dwnld_ctrl

Overview:
Download sequencer between the host ioctl byte stream and the game's memories during ROM load.
- Bytes below PROM_START are queued in a small FIFO and issued to the SDRAM controller through a req/ack handshake with byte masks.
- Bytes at or above PROM_START become single-cycle write strobes to six on-chip PROMs.
- The block throttles the host with ioctl_wait and holds the game in reset until every queued write has retired, plus a guard interval.

Parameters:
PROM_START, 65536, first ioctl address routed to the PROM path.
FIFO_AW, 2, log2 of SDRAM write FIFO depth (default depth 4).
RST_HOLD, 16, clk cycles game_rst_n stays low after the download is fully drained; minimum 1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
downloading  in  1  host download window active.
ioctl_addr  in  22  byte address of the current host write.
ioctl_data  in  8  byte data.
ioctl_wr  in  1  one-cycle byte write strobe.
ioctl_wait  out  1  host must hold further writes; high while FIFO full.
sdram_req  out  1  write request to SDRAM controller.
sdram_ack  in  1  request accepted; sampled only while sdram_req=1.
sdram_addr  out  22  word address, equal to {1'b0, ioctl_addr[21:1]}.
sdram_data  out  16  byte duplicated on both halves.
sdram_mask  out  2  active-low byte mask, equal to {a0, ~a0}.
prom_addr  out  10  PROM byte address.
prom_data  out  8  PROM byte data.
prom_we  out  6  one-hot PROM write strobe, one cycle.
ovf  out  1  sticky: a write arrived while full and was dropped.
dwnld_busy  out  1  download in progress or SDRAM writes pending.
game_rst_n  out  1  game reset, active low.

Behaviour:
- Reset values (async, rst_n=0):
  - FIFO empty; sdram_req=0; prom_we=0; ovf=0.
  - sdram_addr, sdram_data, sdram_mask, prom_addr, prom_data = 0.
  - game_rst_n=0; hold counter loaded with RST_HOLD.
  - A reset mid-transfer drops the outstanding request immediately; no ack is awaited.
- SDRAM path, classification: ioctl_wr=1 with ioctl_addr < PROM_START is an SDRAM byte.
- SDRAM path, push:
  - If the FIFO is not full, push {addr>>1, {data,data}, {a0,~a0}}.
  - If full, drop the byte and set ovf=1 (sticky until reset).
  - A push is rejected while full even if a pop happens in the same cycle.
- ioctl_wait is combinational: count == 2^FIFO_AW.
- Issue FSM, two states:
  - IDLE: if the FIFO is non-empty, load sdram_addr/data/mask from the head and set sdram_req=1 at the next edge, then go to REQ.
  - REQ: hold sdram_req and all fields stable until sdram_ack=1. On that edge, pop the FIFO, clear sdram_req, and return to IDLE.
  - The mandatory IDLE cycle gives a minimum 2-cycle spacing between requests.
  - Push-to-req latency: push at edge N gives sdram_req=1 at edge N+1 when the FSM was IDLE with an empty FIFO.
- FIFO pointers wrap modulo 2^FIFO_AW. The count is FIFO_AW+1 bits wide, so full and empty are never ambiguous.
- PROM path:
  - ioctl_wr=1 with ioctl_addr >= PROM_START: off = ioctl_addr - PROM_START.
  - If off < 6144: at the next edge prom_addr=off[9:0], prom_data=ioctl_data, and prom_we has bit off[12:10] set for exactly one cycle.
  - If off >= 6144: the byte is ignored, with no strobe and no ovf.
  - The PROM path never asserts ioctl_wait.
- dwnld_busy = downloading | FIFO non-empty | sdram_req, registered with a one-cycle delay.
- game_rst_n:
  - Low while dwnld_busy=1; the counter reloads to RST_HOLD.
  - Once dwnld_busy=0, the counter decrements each cycle; game_rst_n goes high on the edge the counter reaches 0.
  - dwnld_busy rising again drops game_rst_n the next cycle.
- ioctl_wr while downloading=0 is still processed normally.

Optional Feature:
JTPOPEYE_DWNLD_CHK_EN
- Defined: adds output chk[15:0], the 16-bit wrapping sum of every accepted ioctl byte on both paths, excluding dropped or ignored bytes.
  - chk clears on reset and on the rising edge of downloading.
  - Sampled by the bench after dwnld_busy falls.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single write: addr=0x000101, data=0xA5, sdram_ack tied high one cycle after req.
  -> sdram_req at N+1; sdram_addr=0x000080, sdram_data=0xA5A5, sdram_mask=2'b10; then the FIFO is empty.
- Backpressure: sdram_ack=0, 5 SDRAM writes on consecutive cycles.
  -> ioctl_wait=1 after the 4th; 5th dropped, ovf=1.
  -> After ack is released, exactly 4 requests complete, in order.
- PROM strobe: addr=PROM_START+0x0C07, data=0x3C.
  -> prom_we=6'b001000, prom_addr=0x007, prom_data=0x3C for one cycle.
  -> addr=PROM_START+0x1800 produces no strobe.
- Reset release: downloading falls with 2 entries pending and ack delayed 3 cycles each.
  -> game_rst_n rises exactly RST_HOLD cycles after dwnld_busy falls, never earlier.
- Async reset mid-REQ: rst_n low while sdram_req=1.
  -> sdram_req=0 immediately; after release, FIFO empty and game_rst_n=0.
- With JTPOPEYE_DWNLD_CHK_EN: bytes 0xFF,0x02,0x10 accepted -> chk=0x0111.
